seg595_scan_driver: RTL and testbench

- Parametrised successor to the fixed 4-digit hex 595 display driver: scans 1..8 multiplexed 7-segment digits through two cascaded 74HC595s (segment byte, then digit-select byte).
- Adds per-digit decimal point, per-digit enable, leading-zero suppression, selectable polarity, programmable shift clock and dwell time, and tear-free frame snapshots.
- Runs on the raw board clock beside the Qsys system; its inputs are driven from a PIO word.

---
 rtl/seg595_pkg.sv | 23 ++
 rtl/seg595_scan_driver_dec.sv | 12 +
 rtl/seg595_scan_driver.sv | 208 ++++++++++++++++++++
 tb/tb_seg595_scan_driver.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg595_pkg.sv
// seg595_pkg: shared constants for the 595 scan driver.
// Holds the hex decode table, frame widths and FSM state encoding.
package seg595_pkg;

    localparam int SEG_BITS   = 8;
    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DWELL
    } state_t;

    // Segment order g,f,e,d,c,b,a; 1 = segment lit.
    localparam logic [6:0] HEX7SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg595_scan_driver_dec.sv
// hex7seg_dec: combinational hex nibble to 7-segment decode.
// Ports: nibble (4b in), seg (7b out, g..a, active-high).
module hex7seg_dec
    import seg595_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX7SEG[nibble];

endmodule

// File: rtl/seg595_scan_driver.sv
// seg595_scan_driver: scans 1..8 7-segment digits via two 595s.
// Ports: sys_clk, sys_rst_n, hex_data, dp, digit_en, lz_suppress in;
//        clk/dat/str to the 595 chain, frame_done pulse out.
module seg595_scan_driver
    import seg595_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV            = 2,
    parameter int DWELL          = 0,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [4*DIGITS-1:0]   hex_data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lz_suppress,
    output logic                  clk,
    output logic                  dat,
    output logic                  str,
    output logic                  frame_done
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DWL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'((DWELL > 0) ? DWELL - 1 : 0);
    localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

    state_t                state, state_n;
    logic [2:0]            idx, idx_n;
    logic [3:0]            bitc, bitc_n;
    logic [DIV_W-1:0]      dcnt, dcnt_n;
    logic                  hi, hi_n;
    logic [DWL_W-1:0]      wcnt, wcnt_n;
    logic [FRAME_BITS-1:0] sh, sh_n;
    logic                  clk_n, dat_n, str_n, fd_n;

    logic [4*DIGITS-1:0]   shd_hex;
    logic [DIGITS-1:0]     shd_dp;
    logic [DIGITS-1:0]     shd_en;
    logic                  shd_lz;

    // Digit 0 reads the live inputs because the snapshot lands on
    // the same edge that leaves LOAD.
    logic                  use_live;
    logic [4*DIGITS-1:0]   src_hex;
    logic [DIGITS-1:0]     src_dp;
    logic [DIGITS-1:0]     src_en;
    logic                  src_lz;

    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  en_bit;
    logic                  upper_zero;
    logic                  blank;
    logic [6:0]            seg7;
    logic [SEG_BITS-1:0]   seg_raw, sel_raw;
    logic [FRAME_BITS-1:0] word;

    assign use_live = (idx == 3'd0);
    assign src_hex  = use_live ? hex_data    : shd_hex;
    assign src_dp   = use_live ? dp          : shd_dp;
    assign src_en   = use_live ? digit_en    : shd_en;
    assign src_lz   = use_live ? lz_suppress : shd_lz;

    always_comb begin
        nib        = 4'h0;
        dp_bit     = 1'b0;
        en_bit     = 1'b0;
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (idx == 3'(j)) begin
                nib    = src_hex[4*j +: 4];
                dp_bit = src_dp[j];
                en_bit = src_en[j];
            end
            if (3'(j) >= idx && src_hex[4*j +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
    end

    hex7seg_dec u_dec (
        .nibble (nib),
        .seg    (seg7)
    );

    assign blank   = !en_bit || (src_lz && upper_zero && idx != 3'd0);
    assign seg_raw = blank ? '0 : {dp_bit, seg7};
    assign sel_raw = blank ? '0 : (8'b1 << idx);
    assign word    = {SEG_ACTIVE_LOW ? ~seg_raw : seg_raw,
                      SEL_ACTIVE_LOW ? ~sel_raw : sel_raw};

    always_comb begin
        state_n = state;
        idx_n   = idx;
        bitc_n  = bitc;
        dcnt_n  = dcnt;
        hi_n    = hi;
        wcnt_n  = wcnt;
        sh_n    = sh;
        fd_n    = 1'b0;
        unique case (state)
            ST_LOAD: begin
                sh_n    = word;
                bitc_n  = 4'd0;
                dcnt_n  = '0;
                hi_n    = 1'b0;
                state_n = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (dcnt == DIV_LAST) begin
                    dcnt_n = '0;
                    hi_n   = !hi;
                    if (hi) begin
                        sh_n = sh << 1;
                        if (bitc == 4'd15)
                            state_n = ST_LATCH;
                        else
                            bitc_n = bitc + 4'd1;
                    end
                end else begin
                    dcnt_n = dcnt + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (dcnt == DIV_LAST) begin
                    dcnt_n = '0;
                    hi_n   = !hi;
                    if (hi) begin
                        if (DWELL == 0) begin
                            state_n = ST_LOAD;
                        end else begin
                            wcnt_n  = '0;
                            state_n = ST_DWELL;
                        end
                    end
                end else begin
                    dcnt_n = dcnt + DIV_W'(1);
                end
            end
            ST_DWELL: begin
                if (wcnt == DWL_LAST)
                    state_n = ST_LOAD;
                else
                    wcnt_n = wcnt + DWL_W'(1);
            end
            default: state_n = ST_LOAD;
        endcase
        // Any return to LOAD advances the digit index.
        if (state != ST_LOAD && state_n == ST_LOAD) begin
            idx_n = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            fd_n  = (idx == IDX_LAST);
        end
    end

    // Pin values are derived from next-state values so they come
    // straight out of flops with no decode glitches.
    always_comb begin
        clk_n = (state_n == ST_SHIFT) && hi_n;
        str_n = (state_n == ST_LATCH) && !hi_n;
        dat_n = (state_n == ST_SHIFT) ? sh_n[FRAME_BITS-1] : 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_LOAD;
            idx        <= 3'd0;
            bitc       <= 4'd0;
            dcnt       <= '0;
            hi         <= 1'b0;
            wcnt       <= '0;
            sh         <= '0;
            clk        <= 1'b0;
            dat        <= 1'b0;
            str        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            bitc       <= bitc_n;
            dcnt       <= dcnt_n;
            hi         <= hi_n;
            wcnt       <= wcnt_n;
            sh         <= sh_n;
            clk        <= clk_n;
            dat        <= dat_n;
            str        <= str_n;
            frame_done <= fd_n;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shd_hex <= '0;
            shd_dp  <= '0;
            shd_en  <= '0;
            shd_lz  <= 1'b0;
        end else if (state == ST_LOAD && idx == 3'd0) begin
            shd_hex <= hex_data;
            shd_dp  <= dp;
            shd_en  <= digit_en;
            shd_lz  <= lz_suppress;
        end
    end

endmodule

// File: tb/tb_seg595_scan_driver.sv
// tb_seg595_scan_driver: directed checks of the 595 scan driver.
// Deserialises the 595 pins and compares latched words per digit.
module tb_seg595_scan_driver;

    localparam int DIGITS = 4;
    localparam int DIV    = 2;
    localparam int DWELL  = 0;
    localparam int FRAME  = DIGITS * (1 + 34 * DIV + DWELL);

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] hex_data = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  digit_en = 4'hF;
    logic        lz_suppress = 1'b0;
    logic        clk, dat, str, frame_done;

    always #5 sys_clk = ~sys_clk;

    seg595_scan_driver #(
        .DIGITS         (DIGITS),
        .DIV            (DIV),
        .DWELL          (DWELL),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .hex_data    (hex_data),
        .dp          (dp),
        .digit_en    (digit_en),
        .lz_suppress (lz_suppress),
        .clk         (clk),
        .dat         (dat),
        .str         (str),
        .frame_done  (frame_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pin monitor: shifts dat on each clk rise, pushes on str rise.
    logic [15:0] mon_sh = 16'h0;
    int          mon_bits = 0;
    logic        clk_q = 1'b0;
    logic        str_q = 1'b0;
    logic [15:0] words[$];
    int          lens[$];
    int          cyc = 0;
    int          fd_t = 0;
    int          fd_prev_t = 0;

    always @(negedge sys_clk) begin
        cyc++;
        if (!sys_rst_n) begin
            mon_bits = 0;
            clk_q    = 1'b0;
            str_q    = 1'b0;
        end else begin
            if (clk && !clk_q) begin
                mon_sh = {mon_sh[14:0], dat};
                mon_bits++;
            end
            if (str && !str_q) begin
                words.push_back(mon_sh);
                lens.push_back(mon_bits);
                mon_bits = 0;
            end
            if (frame_done) begin
                fd_prev_t = fd_t;
                fd_t      = cyc;
            end
            clk_q = clk;
            str_q = str;
        end
    end

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        @(negedge sys_clk);
        while (!frame_done && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        if (!frame_done) begin
            total++;
            bad++;
            $display("FAIL %s: frame_done timeout got 0 expected 1", name);
        end
    endtask

    task automatic wait_words(input int cnt, input string name);
        int n;
        n = 0;
        while (words.size() < cnt && n < 5000) begin
            @(negedge sys_clk);
            n++;
        end
        if (words.size() < cnt) begin
            total++;
            bad++;
            $display("FAIL %s: word timeout got %0d expected %0d",
                     name, words.size(), cnt);
        end
    endtask

    function automatic logic [15:0] word_at(input int i);
        return (i < words.size()) ? words[i] : 16'hxxxx;
    endfunction

    function automatic int len_at(input int i);
        return (i < lens.size()) ? lens[i] : -1;
    endfunction

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dpv;
        logic [3:0]  en;
        logic        lz;
        logic [15:0] w [4];
    } vec_t;

    vec_t vt [8];

    task automatic set_vec(input int i, input logic [15:0] h,
                           input logic [3:0] d, input logic [3:0] e,
                           input logic l, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3);
        vt[i].hex  = h;
        vt[i].dpv  = d;
        vt[i].en   = e;
        vt[i].lz   = l;
        vt[i].w[0] = w0;
        vt[i].w[1] = w1;
        vt[i].w[2] = w2;
        vt[i].w[3] = w3;
    endtask

    initial begin
        int n;
        set_vec(0, 16'h12AF, 4'h0, 4'hF, 1'b0,
                16'h8EFE, 16'h88FD, 16'hA4FB, 16'hF9F7);
        set_vec(1, 16'h0005, 4'h0, 4'hF, 1'b1,
                16'h92FE, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_vec(2, 16'h0005, 4'h0, 4'hF, 1'b0,
                16'h92FE, 16'hC0FD, 16'hC0FB, 16'hC0F7);
        set_vec(3, 16'h0000, 4'b0010, 4'hF, 1'b0,
                16'hC0FE, 16'h40FD, 16'hC0FB, 16'hC0F7);
        set_vec(4, 16'h0000, 4'h0, 4'b1110, 1'b0,
                16'hFFFF, 16'hC0FD, 16'hC0FB, 16'hC0F7);
        set_vec(5, 16'h0305, 4'h0, 4'hF, 1'b1,
                16'h92FE, 16'hC0FD, 16'hB0FB, 16'hFFFF);
        set_vec(6, 16'h0000, 4'b0100, 4'hF, 1'b1,
                16'hC0FE, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_vec(7, 16'h8B6D, 4'b1001, 4'hF, 1'b0,
                16'h21FE, 16'h82FD, 16'h83FB, 16'h00F7);

        sys_rst_n = 1'b0;
        repeat (20) @(negedge sys_clk);
        check("rst_clk", 32'(clk), 0);
        check("rst_dat", 32'(dat), 0);
        check("rst_str", 32'(str), 0);
        check("rst_frame_done", 32'(frame_done), 0);

        sys_rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge sys_clk);
            #1;
            n++;
        end while (!clk && n < 100);
        check("first_clk_rise", n, 1 + DIV);
        wait_words(1, "first_word");
        check("first_word", 32'(word_at(0)), 32'h0000C0FE);

        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            hex_data    = vt[i].hex;
            dp          = vt[i].dpv;
            digit_en    = vt[i].en;
            lz_suppress = vt[i].lz;
            wait_fd($sformatf("vec%0d_fd", i));
            words.delete();
            lens.delete();
            wait_words(4, $sformatf("vec%0d_words", i));
            for (int d = 0; d < 4; d++)
                check($sformatf("vec%0d_digit%0d", i, d),
                      32'(word_at(d)), 32'(vt[i].w[d]));
            check($sformatf("vec%0d_bits", i),
                  len_at(0) + len_at(1) + len_at(2) + len_at(3), 64);
        end

        wait_fd("period_fd0");
        @(negedge sys_clk);
        check("frame_done_width", 32'(frame_done), 0);
        words.delete();
        wait_fd("period_fd1");
        check("frame_period", fd_t - fd_prev_t, FRAME);
        check("str_per_frame", words.size(), 4);

        // Input change during digit 1 shift must wait for next frame.
        @(negedge sys_clk);
        hex_data    = 16'h1111;
        dp          = 4'h0;
        digit_en    = 4'hF;
        lz_suppress = 1'b0;
        wait_fd("tear_fd");
        words.delete();
        wait_words(1, "tear_w0");
        repeat (20) @(negedge sys_clk);
        hex_data = 16'h2222;
        wait_words(8, "tear_words");
        check("tear_d0", 32'(word_at(0)), 32'h0000F9FE);
        check("tear_d1", 32'(word_at(1)), 32'h0000F9FD);
        check("tear_d2", 32'(word_at(2)), 32'h0000F9FB);
        check("tear_d3", 32'(word_at(3)), 32'h0000F9F7);
        check("next_d0", 32'(word_at(4)), 32'h0000A4FE);
        check("next_d1", 32'(word_at(5)), 32'h0000A4FD);
        check("next_d2", 32'(word_at(6)), 32'h0000A4FB);
        check("next_d3", 32'(word_at(7)), 32'h0000A4F7);

        // Reset pulse in the high phase of bit 7 of digit 2.
        wait_fd("mid_fd");
        words.delete();
        wait_words(2, "mid_w");
        n = 0;
        while (mon_bits < 8 && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        check("mid_bit7_clk_high", 32'(clk), 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_clk", 32'(clk), 0);
        check("mid_rst_str", 32'(str), 0);
        check("mid_rst_dat", 32'(dat), 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        words.delete();
        lens.delete();
        wait_words(4, "post_rst_words");
        check("post_rst_d0", 32'(word_at(0)), 32'h0000A4FE);
        check("post_rst_d1", 32'(word_at(1)), 32'h0000A4FD);
        check("post_rst_d2", 32'(word_at(2)), 32'h0000A4FB);
        check("post_rst_d3", 32'(word_at(3)), 32'h0000A4F7);
        check("post_rst_bits0", len_at(0), 16);
        wait_fd("post_rst_fd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
